mc10_ram_arbiter: RTL

//  Shares the single-port synchronous main RAM between three requesters: VDG fetch (video), 6803 CPU, and the HPS loader (quickload/tape image writes).
//  It sits in the mc10 core between the requesters and the RAM macro, and is clocked by clk_sys.

---
 rtl/mc10_ram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mc10_ram_arbiter.sv
// mc10 main RAM arbiter: shares the single-port synchronous RAM between
// VDG fetch, the 6803 CPU and the HPS loader. Fixed priority VDG > CPU > loader,
// with the loader promoted above the CPU after LDR_MAX_WAIT starved cycles.
// Each access takes three clocks: IDLE (grant) -> ADDR (RAM samples) -> DATA (ack).
module mc10_ram_arbiter #(
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int LDR_MAX_WAIT = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vdg_req,
    input  logic [AW-1:0] vdg_addr,
    output logic          vdg_ack,
    output logic [DW-1:0] vdg_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    grant_id,
    output logic          busy
);
    localparam int WW = $clog2(LDR_MAX_WAIT + 1);

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_VDG  = 2'b01;
    localparam logic [1:0] G_CPU  = 2'b10;
    localparam logic [1:0] G_LDR  = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state, state_nx;
    logic [1:0]    pick;
    logic [WW-1:0] wait_cnt;
    logic          gnt_rd;
    logic          vdg_elig, cpu_elig, ldr_elig, ldr_promo;

    // A port acked this cycle still holds req; mask it so it is not re-granted.
    assign vdg_elig  = vdg_req & ~vdg_ack;
    assign cpu_elig  = cpu_req & ~cpu_ack;
    assign ldr_elig  = ldr_req & ~ldr_ack;
    assign ldr_promo = (wait_cnt == WW'(LDR_MAX_WAIT));
    assign busy      = (state != IDLE);

    // Next state and grant selection (a pick is only made in IDLE)
    always_comb begin
        state_nx = state;
        pick     = G_NONE;
        case (state)
            IDLE: begin
                if (vdg_elig)                  pick = G_VDG;
                else if (ldr_elig && ldr_promo) pick = G_LDR;
                else if (cpu_elig)             pick = G_CPU;
                else if (ldr_elig)             pick = G_LDR;
                if (pick != G_NONE) state_nx = ADDR;
            end
            ADDR:    state_nx = DATA;
            DATA:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // RAM port, grant tracking, read data capture and ack pulses
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
            grant_id  <= G_NONE;
            gnt_rd    <= 1'b0;
            vdg_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            vdg_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            vdg_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != G_NONE) begin
                        grant_id <= pick;
                        case (pick)
                            G_VDG: begin
                                ram_addr <= vdg_addr;
                                ram_we   <= 1'b0;
                                gnt_rd   <= 1'b1;
                            end
                            G_CPU: begin
                                ram_addr <= cpu_addr;
                                ram_we   <= cpu_we;
                                ram_din  <= cpu_wdata;
                                gnt_rd   <= ~cpu_we;
                            end
                            default: begin
                                ram_addr <= ldr_addr;
                                ram_we   <= 1'b1;
                                ram_din  <= ldr_wdata;
                                gnt_rd   <= 1'b0;
                            end
                        endcase
                    end
                end
                ADDR: ram_we <= 1'b0;
                DATA: begin
                    grant_id <= G_NONE;
                    case (grant_id)
                        G_VDG: begin
                            vdg_ack   <= 1'b1;
                            vdg_rdata <= ram_dout;
                        end
                        G_CPU: begin
                            cpu_ack <= 1'b1;
                            if (gnt_rd) cpu_rdata <= ram_dout;
                        end
                        G_LDR:   ldr_ack <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Loader starvation counter: counts edges spent waiting, saturating
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                      wait_cnt <= '0;
        else if (!ldr_req || pick == G_LDR) wait_cnt <= '0;
        else if (!ldr_promo)               wait_cnt <= wait_cnt + WW'(1);
    end
endmodule
